psum_drain_ctrl: RTL and testbench



---
 rtl/psum_drain_ctrl_pkg.sv | 12 +
 rtl/psum_drain_ctrl_fifo.sv | 38 +++
 rtl/psum_drain_ctrl.sv | 92 +++++++++
 tb/tb_psum_drain_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/psum_drain_ctrl_pkg.sv
// psum_drain_ctrl_pkg: shared types, defaults and helpers for the psum drain controller
package psum_drain_ctrl_pkg;
  localparam int COL_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 8;
  typedef logic signed [DW_DEF-1:0] psum_t;
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} drain_state_e;
  // cycle counter must cover 255 rows plus the full column skew without wrapping
  function automatic int t_width(int col);
    return 8 + $clog2(col) + 1;
  endfunction
endpackage

// File: rtl/psum_drain_ctrl_fifo.sv
// psum_drain_ctrl_fifo: first-word fall-through row FIFO; a push on full succeeds only with a same-cycle pop
module psum_drain_ctrl_fifo
  import psum_drain_ctrl_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         wr, rd;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = empty ? '0 : mem[rp[AW-1:0]];
  // pointer advance; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(rd);
    end
  // storage needs no reset: dout is masked while empty
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl: drains skewed systolic column psums into aligned rows and queues them; optional SYS_OUT_RELU_EN clamps negative lanes to 0
module psum_drain_ctrl
  import psum_drain_ctrl_pkg::*;
#(
  parameter int COL        = COL_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              conv_finish,
  input  logic [7:0]        n_rows,
  input  logic [DW-1:0]     psum_in [COL-1:0],
  output logic [COL-1:0]    out_en,
  output logic [COL*DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              drain_busy,
  output logic              drain_done,
  output logic              overflow,
  input  logic              clear_ovf
);
  localparam int TW = t_width(COL);
  drain_state_e      state;
  logic [TW-1:0]     t, nr_w, last;
  logic [7:0]        nr;
  logic              conv_finish_q, start, push, pop, full, empty, drop;
  logic [COL*DW-1:0] row;
  assign start      = conv_finish && !conv_finish_q && state == IDLE;
  assign nr_w       = TW'(nr);
  assign last       = nr_w + TW'(COL - 1);
  assign push       = state == COLLECT && t >= TW'(COL);
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign drop       = push && full && !pop;
  assign drain_busy = state != IDLE;
  assign drain_done = state == FLUSH && empty;
  for (genvar c = 0; c < COL; c++) begin : g_lane
    localparam int D = COL - 1 - c;
    logic [DW-1:0] sh [D+1];
    // t-c wraps far above any n_rows when t<c, so one unsigned compare gives the diagonal window
    assign out_en[c] = state == COLLECT && (t - TW'(c)) < nr_w;
    // capture on the window, then delay so every lane of row r lands at t=r+COL
    always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
        for (int i = 0; i <= D; i++) sh[i] <= '0;
      end else begin
        if (out_en[c]) sh[0] <= psum_in[c];
        for (int i = 1; i <= D; i++) sh[i] <= sh[i-1];
      end
`ifdef SYS_OUT_RELU_EN
    assign row[c*DW +: DW] = sh[D][DW-1] ? '0 : sh[D];
`else
    assign row[c*DW +: DW] = sh[D];
`endif
  end
  psum_drain_ctrl_fifo #(.W(COL*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .nrst (nrst),
    .push (push),
    .pop  (pop),
    .din  (row),
    .dout (out_data),
    .full (full),
    .empty(empty)
  );
  // drain sequencing, start-edge detect and sticky overflow (a new drop beats a clear)
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state         <= IDLE;
      t             <= '0;
      nr            <= '0;
      conv_finish_q <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      conv_finish_q <= conv_finish;
      overflow      <= drop || (overflow && !clear_ovf);
      case (state)
        IDLE: if (start) begin
          nr    <= n_rows;
          t     <= '0;
          state <= n_rows != 8'd0 ? COLLECT : FLUSH;
        end
        COLLECT: begin
          t <= t + TW'(1);
          if (t == last) state <= FLUSH;
        end
        FLUSH: if (empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_psum_drain_ctrl.sv
// tb_psum_drain_ctrl: table-driven, directed and random checks of psum_drain_ctrl against a row-queue model
module tb_psum_drain_ctrl;
  localparam int COL = 4;
  localparam int DW  = 16;
  localparam int FD  = 4;
  typedef struct {
    int nr;
    int hold;
    bit glitch;
    bit neg;
    int exp_rows;
    int exp_done;
    bit exp_ovf;
  } vec_t;
  logic              clk = 0, nrst = 0, conv_finish = 0, out_ready = 0, clear_ovf = 0;
  logic [7:0]        n_rows = 0;
  logic [DW-1:0]     psum_in [COL-1:0];
  logic [COL-1:0]    out_en;
  logic [COL*DW-1:0] out_data;
  logic              out_valid, drain_busy, drain_done, overflow;
  int                checks = 0, errors = 0;
  logic [COL*DW-1:0] q[$];
  logic              ovf_m = 0;
  logic [DW-1:0]     vals [8][COL];
  int                delivered, dut_done_k;
  logic [DW-1:0]     first_lane0;
  vec_t              tbl [8];

  always #5 clk = ~clk;

  psum_drain_ctrl #(.COL(COL), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .nrst(nrst), .conv_finish(conv_finish), .n_rows(n_rows), .psum_in(psum_in),
    .out_en(out_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drain_busy(drain_busy), .drain_done(drain_done), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [COL*DW-1:0] row_of(int r);
    logic [COL*DW-1:0] v;
    for (int c = 0; c < COL; c++) begin
`ifdef SYS_OUT_RELU_EN
      v[c*DW +: DW] = vals[r][c][DW-1] ? '0 : vals[r][c];
`else
      v[c*DW +: DW] = vals[r][c];
`endif
    end
    return v;
  endfunction

  task automatic chk_fifo_side();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
    chk("overflow", 64'(overflow), 64'(ovf_m));
  endtask

  task automatic idle(int n, bit clr);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      clear_ovf = clr;
      #1;
      chk("idle_en", 64'(out_en), 64'(0));
      chk("idle_busy", 64'(drain_busy), 64'(0));
      chk("idle_done", 64'(drain_done), 64'(0));
      chk_fifo_side();
      ovf_m = ovf_m & !clr;
      @(negedge clk);
    end
    clear_ovf = 0;
  endtask

  // cycle k=0 is the start-edge cycle; COLLECT cycle t is k=t+1
  task automatic run_drain(int nr, int hold, bit glitch, bit rnd);
    bit fin, col, push, pop, drop, clr, rdy, exp_done;
    int k, t;
    logic [COL-1:0] en;
    fin = 0; k = 0; delivered = 0; dut_done_k = -1;
    while (!fin && k < 300) begin
      t = k - 1;
      col = nr > 0 && k >= 1 && t <= nr - 1 + COL;
      for (int c = 0; c < COL; c++) en[c] = col && t >= c && t < c + nr;
      if (k == 0) begin
        conv_finish = 1;
        n_rows = 8'(nr);
      end else begin
        n_rows = 8'($urandom);
        conv_finish = !(glitch && k == 2);
      end
      for (int c = 0; c < COL; c++) psum_in[c] = en[c] ? vals[t-c][c] : DW'($urandom);
      rdy = rnd ? ($urandom_range(0, 9) < 6) : (k > hold);
      clr = rnd && $urandom_range(0, 9) == 0;
      out_ready = rdy;
      clear_ovf = clr;
      #1;
      exp_done = k >= 1 && !col && q.size() == 0;
      chk("out_en", 64'(out_en), 64'(en));
      chk("drain_busy", 64'(drain_busy), 64'(k >= 1));
      chk("drain_done", 64'(drain_done), 64'(exp_done));
      chk_fifo_side();
      if (drain_done && dut_done_k < 0) dut_done_k = k;
      if (out_valid && rdy) begin
        if (delivered == 0) first_lane0 = out_data[DW-1:0];
        delivered++;
      end
      if (exp_done) fin = 1;
      pop = rdy && q.size() > 0;
      push = col && t >= COL;
      if (pop) void'(q.pop_front());
      drop = push && q.size() >= FD;
      if (push && !drop) q.push_back(row_of(t - COL));
      ovf_m = drop | (ovf_m & !clr);
      @(negedge clk);
      k++;
    end
    clear_ovf = 0;
    if (!fin) chk("drain_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    tbl[0] = '{3, 0, 0, 0, 3, 9, 0};
    tbl[1] = '{6, 20, 0, 0, 4, 25, 1};
    tbl[2] = '{0, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{4, 20, 0, 0, 4, 25, 0};
    tbl[4] = '{5, 8, 0, 0, 5, 14, 0};
    tbl[5] = '{5, 9, 0, 0, 4, 14, 1};
    tbl[6] = '{2, 0, 1, 0, 2, 8, 0};
    tbl[7] = '{1, 0, 0, 1, 1, 7, 0};
    for (int c = 0; c < COL; c++) psum_in[c] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_en", 64'(out_en), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(drain_busy), 64'(0));
    chk("rst_done", 64'(drain_done), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    @(negedge clk);
    nrst = 1;
    idle(2, 0);
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < COL; c++) vals[r][c] = DW'(16 * r + c);
      if (tbl[i].neg) vals[0][0] = 16'hFFFB;
      run_drain(tbl[i].nr, tbl[i].hold, tbl[i].glitch, 0);
      chk("tbl_rows", 64'(delivered), 64'(tbl[i].exp_rows));
      chk("tbl_done_cycle", 64'(dut_done_k), 64'(tbl[i].exp_done));
      chk("tbl_ovf", 64'(overflow), 64'(tbl[i].exp_ovf));
`ifdef SYS_OUT_RELU_EN
      if (tbl[i].neg) chk("relu_lane0", 64'(first_lane0), 64'(16'h0000));
`else
      if (tbl[i].neg) chk("relu_lane0", 64'(first_lane0), 64'(16'hFFFB));
`endif
      idle(2, 0);
      conv_finish = 0;
      idle(1, 1);
      idle(1, 0);
    end
    for (int i = 0; i < 25; i++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < COL; c++) vals[r][c] = DW'($urandom);
      run_drain($urandom_range(0, 7), 0, 0, 1);
      conv_finish = 0;
      idle(2, 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < COL; c++) vals[r][c] = DW'(16 * r + c);
    conv_finish = 1;
    n_rows = 3;
    out_ready = 1;
    repeat (3) @(negedge clk);
    nrst = 0;
    #1;
    chk("midrst_en", 64'(out_en), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy", 64'(drain_busy), 64'(0));
    chk("midrst_ovf", 64'(overflow), 64'(0));
    conv_finish = 0;
    q.delete();
    ovf_m = 0;
    @(negedge clk);
    nrst = 1;
    idle(10, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
